// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline encodings: icodes, register/status codes, control FSM states.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    // Instruction codes as carried in every stage register
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // "No register" code; never matches a real source operand
    localparam logic [3:0] RNONE = 4'hF;

    // Stage status codes
    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // One bundle of stage controls, MSB first in pipeline order
    typedef struct packed {
        logic f_stall;
        logic d_stall;
        logic d_bubble;
        logic e_bubble;
        logic m_bubble;
        logic w_stall;
        logic set_cc_en;
    } ctrl_t;

    // True for the statuses that must stop the machine
    function automatic logic is_exc(input logic [2:0] stat);
        return (stat == S_HLT) || (stat == S_ADR) || (stat == S_INS);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Hazard equations: load-use, pending return, mispredict and exception controls.
// Latency: purely combinational, zero cycles.
// Backpressure: none; results are only meaningful while the pipeline is running.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [3:0] D_icode,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] E_icode,
    input  logic [3:0] E_dstM,
    input  logic       e_cnd,
    input  logic [3:0] M_icode,
    input  logic [2:0] m_stat,
    input  logic [2:0] W_stat,
    output ctrl_t      run_ctrl,
    output logic       mispred
);

    logic load_use;
    logic ret_pend;
    logic exc_m;
    logic exc_w;

    // Raw hazard conditions
    always_comb begin
        load_use = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                   (E_dstM != RNONE) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        ret_pend = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        mispred  = (E_icode == I_JXX) && !e_cnd;
        exc_m    = is_exc(m_stat);
        exc_w    = is_exc(W_stat);
    end

    // Stage controls; a mispredict bubbles decode even when a load-use stalls it
    always_comb begin
        run_ctrl           = '0;
        run_ctrl.f_stall   = load_use | ret_pend;
        run_ctrl.d_stall   = load_use;
        run_ctrl.d_bubble  = mispred | (ret_pend & ~load_use);
        run_ctrl.e_bubble  = mispred | load_use;
        run_ctrl.m_bubble  = exc_m | exc_w;
        run_ctrl.w_stall   = exc_w;
        run_ctrl.set_cc_en = (E_icode == I_OPQ) & ~exc_m & ~exc_w;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: BOOT/RUN/HALTED sequencing, stage controls and perf counters.
// Latency: controls combinational from inputs in RUN; state/counters update next edge.
// Backpressure: none; HALTED holds the pipeline frozen until reset.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  E_dstM,
    input  logic        e_cnd,
    input  logic [3:0]  M_icode,
    input  logic [2:0]  m_stat,
    input  logic [2:0]  W_stat,
    output logic        F_stall,
    output logic        D_stall,
    output logic        D_bubble,
    output logic        E_bubble,
    output logic        M_bubble,
    output logic        W_stall,
    output logic        set_cc_en,
    output logic        halted,
    output logic [2:0]  stop_code,
    output logic [31:0] cycle_cnt,
    output logic [31:0] stall_cnt,
    output logic [15:0] mispred_cnt
);

    state_t      state_q, state_d;
    logic [2:0]  stop_code_q, stop_code_d;
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] mispred_cnt_q, mispred_cnt_d;

    ctrl_t run_ctrl;
    ctrl_t ctrl;
    logic  mispred;

    hazard_detect u_hazard (
        .D_icode  (D_icode),
        .d_srcA   (d_srcA),
        .d_srcB   (d_srcB),
        .E_icode  (E_icode),
        .E_dstM   (E_dstM),
        .e_cnd    (e_cnd),
        .M_icode  (M_icode),
        .m_stat   (m_stat),
        .W_stat   (W_stat),
        .run_ctrl (run_ctrl),
        .mispred  (mispred)
    );

    // Next state and per-state stage controls
    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        case (state_q)
            ST_BOOT: begin
                ctrl.d_bubble = 1'b1;
                ctrl.e_bubble = 1'b1;
                ctrl.m_bubble = 1'b1;
                state_d       = ST_RUN;
            end
            ST_RUN: begin
                ctrl = run_ctrl;
                if (W_stat != S_AOK) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                ctrl.f_stall  = 1'b1;
                ctrl.d_stall  = 1'b1;
                ctrl.e_bubble = 1'b1;
                ctrl.m_bubble = 1'b1;
                ctrl.w_stall  = 1'b1;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // Counters and stop-code capture; everything freezes once halted
    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        stop_code_d   = stop_code_q;
        if (state_q != ST_HALTED) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
        if (state_q == ST_RUN) begin
            if (run_ctrl.f_stall) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
            if (mispred && (mispred_cnt_q != 16'hFFFF)) begin
                mispred_cnt_d = mispred_cnt_q + 16'd1;
            end
            if (W_stat != S_AOK) begin
                stop_code_d = W_stat;
            end
        end
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            stop_code_q   <= 3'd0;
            cycle_cnt_q   <= 32'd0;
            stall_cnt_q   <= 32'd0;
            mispred_cnt_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            stop_code_q   <= stop_code_d;
            cycle_cnt_q   <= cycle_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign F_stall     = ctrl.f_stall;
    assign D_stall     = ctrl.d_stall;
    assign D_bubble    = ctrl.d_bubble;
    assign E_bubble    = ctrl.e_bubble;
    assign M_bubble    = ctrl.m_bubble;
    assign W_stall     = ctrl.w_stall;
    assign set_cc_en   = ctrl.set_cc_en;
    assign halted      = (state_q == ST_HALTED);
    assign stop_code   = stop_code_q;
    assign cycle_cnt   = cycle_cnt_q;
    assign stall_cnt   = stall_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
    logic        e_cnd;
    logic [2:0]  m_stat, W_stat;
    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en;
    logic        halted;
    logic [2:0]  stop_code;
    logic [31:0] cycle_cnt, stall_cnt;
    logic [15:0] mispred_cnt;
    logic [6:0]  ctrl_o;

    // Control bit order: F_stall D_stall D_bubble E_bubble M_bubble W_stall set_cc_en
    localparam logic [6:0] C_NONE   = 7'b0000000;
    localparam logic [6:0] C_BOOT   = 7'b0011100;
    localparam logic [6:0] C_HALTED = 7'b1101110;

    assign ctrl_o = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en};

    pipe_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd),
        .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .set_cc_en(set_cc_en), .halted(halted), .stop_code(stop_code),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .mispred_cnt(mispred_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string      name;
        logic [3:0] d_icode, srca, srcb, e_icode, e_dstm;
        logic       cnd;
        logic [3:0] m_icode;
        logic [2:0] mstat;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_vec;
    int   n_err;
    int   exp_cyc, exp_stall, exp_mis;

    function automatic vec_t mk(input string nm, input logic [3:0] di, sa, sb, ei, ed,
                                input logic c, input logic [3:0] mi, input logic [2:0] ms,
                                input logic [6:0] ex);
        vec_t v;
        v.name = nm; v.d_icode = di; v.srca = sa; v.srcb = sb; v.e_icode = ei;
        v.e_dstm = ed; v.cnd = c; v.m_icode = mi; v.mstat = ms; v.exp = ex;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic idle();
        D_icode = I_NOP; d_srcA = RNONE; d_srcB = RNONE;
        E_icode = I_NOP; E_dstM = RNONE; e_cnd = 1'b1;
        M_icode = I_NOP; m_stat = S_AOK; W_stat = S_AOK;
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        exp_cyc = 0; exp_stall = 0; exp_mis = 0;

        tbl.push_back(mk("idle",        I_NOP,    RNONE, RNONE, I_NOP,    RNONE, 1'b1, I_NOP, S_AOK, 7'b0000000));
        tbl.push_back(mk("opq_cc",      I_NOP,    RNONE, RNONE, I_OPQ,    RNONE, 1'b1, I_NOP, S_AOK, 7'b0000001));
        tbl.push_back(mk("lu_mr_srcA",  I_OPQ,    4'd3,  4'd7,  I_MRMOVQ, 4'd3,  1'b1, I_NOP, S_AOK, 7'b1101000));
        tbl.push_back(mk("lu_pop_srcB", I_OPQ,    4'd1,  4'd4,  I_POPQ,   4'd4,  1'b1, I_NOP, S_AOK, 7'b1101000));
        tbl.push_back(mk("lu_rnone",    I_OPQ,    RNONE, RNONE, I_MRMOVQ, RNONE, 1'b1, I_NOP, S_AOK, 7'b0000000));
        tbl.push_back(mk("lu_nomatch",  I_OPQ,    4'd2,  4'd1,  I_MRMOVQ, 4'd3,  1'b1, I_NOP, S_AOK, 7'b0000000));
        tbl.push_back(mk("irmov_match", I_OPQ,    4'd3,  4'd1,  I_IRMOVQ, 4'd3,  1'b1, I_NOP, S_AOK, 7'b0000000));
        tbl.push_back(mk("mispred",     I_NOP,    RNONE, RNONE, I_JXX,    RNONE, 1'b0, I_NOP, S_AOK, 7'b0011000));
        tbl.push_back(mk("jxx_taken",   I_NOP,    RNONE, RNONE, I_JXX,    RNONE, 1'b1, I_NOP, S_AOK, 7'b0000000));
        tbl.push_back(mk("ret_d",       I_RET,    RNONE, RNONE, I_NOP,    RNONE, 1'b1, I_NOP, S_AOK, 7'b1010000));
        tbl.push_back(mk("ret_e",       I_NOP,    RNONE, RNONE, I_RET,    RNONE, 1'b1, I_NOP, S_AOK, 7'b1010000));
        tbl.push_back(mk("ret_m",       I_NOP,    RNONE, RNONE, I_NOP,    RNONE, 1'b1, I_RET, S_AOK, 7'b1010000));
        tbl.push_back(mk("ret_lu",      I_RET,    4'd6,  4'd2,  I_MRMOVQ, 4'd2,  1'b1, I_NOP, S_AOK, 7'b1101000));
        tbl.push_back(mk("mstat_adr",   I_NOP,    RNONE, RNONE, I_OPQ,    RNONE, 1'b1, I_NOP, S_ADR, 7'b0000100));
        tbl.push_back(mk("mstat_hlt",   I_NOP,    RNONE, RNONE, I_OPQ,    RNONE, 1'b1, I_NOP, S_HLT, 7'b0000100));
        tbl.push_back(mk("mstat_ins",   I_NOP,    RNONE, RNONE, I_OPQ,    RNONE, 1'b1, I_NOP, S_INS, 7'b0000100));
        tbl.push_back(mk("mstat_zero",  I_NOP,    RNONE, RNONE, I_OPQ,    RNONE, 1'b1, I_NOP, 3'd0,  7'b0000001));

        // Reset state
        rst_n = 1'b0;
        idle();
        #1;
        chk("rst_ctrl",    {25'd0, ctrl_o}, {25'd0, C_BOOT});
        chk("rst_halted",  {31'd0, halted}, 32'd0);
        chk("rst_stop",    {29'd0, stop_code}, 32'd0);
        chk("rst_cycle",   cycle_cnt, 32'd0);
        chk("rst_stall",   stall_cnt, 32'd0);
        chk("rst_mispred", {16'd0, mispred_cnt}, 32'd0);

        // Release: exactly one BOOT cycle, then RUN
        #11 rst_n = 1'b1;
        #1;
        chk("boot_ctrl",  {25'd0, ctrl_o}, {25'd0, C_BOOT});
        chk("boot_cycle", cycle_cnt, 32'd0);
        tick();
        exp_cyc = 1;
        chk("run_ctrl",  {25'd0, ctrl_o}, {25'd0, C_NONE});
        chk("run_cycle", cycle_cnt, 32'd1);

        // Table of combinational RUN vectors, one cycle each
        for (int i = 0; i < tbl.size(); i++) begin
            D_icode = tbl[i].d_icode; d_srcA = tbl[i].srca; d_srcB = tbl[i].srcb;
            E_icode = tbl[i].e_icode; E_dstM = tbl[i].e_dstm; e_cnd = tbl[i].cnd;
            M_icode = tbl[i].m_icode; m_stat = tbl[i].mstat; W_stat = S_AOK;
            #1;
            chk(tbl[i].name, {25'd0, ctrl_o}, {25'd0, tbl[i].exp});
            tick();
            exp_cyc++;
            if (tbl[i].exp[6]) exp_stall++;
            if (tbl[i].e_icode == I_JXX && !tbl[i].cnd) exp_mis++;
        end
        idle();
        chk("tbl_cycle",   cycle_cnt, exp_cyc);
        chk("tbl_stall",   stall_cnt, exp_stall);
        chk("tbl_mispred", {16'd0, mispred_cnt}, exp_mis);

        // Load-use: single stall cycle counted once
        E_icode = I_MRMOVQ; E_dstM = 4'd3; d_srcA = 4'd3;
        #1;
        chk("lu_ctrl", {25'd0, ctrl_o}, 32'b1101000);
        tick();
        exp_cyc++; exp_stall++;
        idle();
        chk("lu_stall_cnt", stall_cnt, exp_stall);

        // Return in decode for three cycles
        for (int k = 0; k < 3; k++) begin
            D_icode = I_RET;
            #1;
            chk("ret_f_stall",  {31'd0, F_stall}, 32'd1);
            chk("ret_d_bubble", {31'd0, D_bubble}, 32'd1);
            tick();
            exp_cyc++; exp_stall++;
        end
        D_icode = I_RET; E_icode = I_MRMOVQ; E_dstM = 4'd2; d_srcB = 4'd2;
        #1;
        chk("ret_lu_d_bubble", {31'd0, D_bubble}, 32'd0);
        chk("ret_lu_d_stall",  {31'd0, D_stall}, 32'd1);
        tick();
        exp_cyc++; exp_stall++;
        idle();
        chk("ret_stall_cnt", stall_cnt, exp_stall);

        // Mispredict held long enough to saturate the counter
        E_icode = I_JXX; e_cnd = 1'b0;
        #1;
        chk("mis_ctrl", {25'd0, ctrl_o}, 32'b0011000);
        repeat (65535) @(posedge clk);
        #1;
        exp_cyc += 65535;
        chk("mis_sat", {16'd0, mispred_cnt}, 32'h0000FFFF);
        tick();
        exp_cyc++;
        chk("mis_sat_hold", {16'd0, mispred_cnt}, 32'h0000FFFF);
        idle();
        chk("mis_cycle", cycle_cnt, exp_cyc);
        chk("mis_stall", stall_cnt, exp_stall);

        // Exception: memory stage, then writeback, then halt
        E_icode = I_OPQ; m_stat = S_ADR;
        #1;
        chk("exc_m_ctrl", {25'd0, ctrl_o}, 32'b0000100);
        tick();
        exp_cyc++;
        m_stat = S_AOK; W_stat = S_ADR;
        #1;
        chk("exc_w_ctrl", {25'd0, ctrl_o}, 32'b0000110);
        chk("exc_w_not_halted", {31'd0, halted}, 32'd0);
        tick();
        exp_cyc++;
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_stop",   {29'd0, stop_code}, 32'd3);
        chk("halt_ctrl",   {25'd0, ctrl_o}, {25'd0, C_HALTED});
        chk("halt_cycle",  cycle_cnt, exp_cyc);
        // Inputs that would otherwise stall, mispredict or clear the stop
        W_stat = S_AOK; E_icode = I_JXX; e_cnd = 1'b0; D_icode = I_RET;
        repeat (3) tick();
        chk("frz_ctrl",    {25'd0, ctrl_o}, {25'd0, C_HALTED});
        chk("frz_cycle",   cycle_cnt, exp_cyc);
        chk("frz_stall",   stall_cnt, exp_stall);
        chk("frz_mispred", {16'd0, mispred_cnt}, 32'h0000FFFF);
        chk("frz_stop",    {29'd0, stop_code}, 32'd3);
        chk("frz_halted",  {31'd0, halted}, 32'd1);

        // Asynchronous reset while halted, away from any clock edge
        #1 rst_n = 1'b0;
        #1;
        chk("arst_halted",  {31'd0, halted}, 32'd0);
        chk("arst_stop",    {29'd0, stop_code}, 32'd0);
        chk("arst_cycle",   cycle_cnt, 32'd0);
        chk("arst_stall",   stall_cnt, 32'd0);
        chk("arst_mispred", {16'd0, mispred_cnt}, 32'd0);
        chk("arst_ctrl",    {25'd0, ctrl_o}, {25'd0, C_BOOT});
        idle();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rerun_ctrl",  {25'd0, ctrl_o}, {25'd0, C_NONE});
        chk("rerun_cycle", cycle_cnt, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
